shift_rx: RTL and testbench

Serial-to-parallel frame receiver: the receiving end of the serial link that the universal shift register drives from its Lin/Rin shift path. It collects `WIDTH` serial bits per frame, qualified by a bit-enable and marked by a start-of-frame strobe, and assembles them into a parallel word. The word is presented through a one-entry output register with a valid/ready handshake. It sits between the serial pin-side logic and any parallel consumer, and reports overflow and framing errors through sticky flags.

---
 rtl/shift_rx_pkg.sv | 12 +
 rtl/shift_rx_shifter.sv | 38 +++
 rtl/shift_rx.sv | 115 +++++++++++
 tb/tb_shift_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_rx_pkg.sv
// shift_rx shared definitions: FSM encoding and default frame width.
// Imported by the receiver top level and its shifter.
package shift_rx_pkg;

    localparam int RX_WIDTH_DEF = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/shift_rx_shifter.sv
// rx_shifter: enable-gated serial-in shift register.
// Direction selects whether the first bit ends up at the MSB or LSB.
module rx_shifter #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            if (MSB_FIRST) begin
                q_d = {q_q[WIDTH-2:0], din};
            end else begin
                q_d = {din, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_rx.sv
// shift_rx: serial-to-parallel frame receiver with a one-entry
// valid/ready output register and sticky overflow/framing flags.
module shift_rx
    import shift_rx_pkg::*;
#(
    parameter int WIDTH     = RX_WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sen,
    input  logic             sof,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             dready,
    output logic             busy,
    output logic             ovf,
    output logic             ferr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovf_q, ovf_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] word;
    logic             take, done;

    assign take    = sen & (sof | (state_q == ST_SHIFT));
    assign cnt_nxt = sof ? CW'(1) : cnt_q + CW'(1);
    assign done    = take & (cnt_nxt == LAST);

    rx_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (take),
        .din   (sin),
        .q     (sh_q)
    );

    // The completed word includes the bit being shifted in this cycle.
    always_comb begin
        if (MSB_FIRST) begin
            word = {sh_q[WIDTH-2:0], sin};
        end else begin
            word = {sin, sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        ovf_d    = ovf_q & ~clr;
        ferr_d   = ferr_q & ~clr;
        if (take) begin
            if (done) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_SHIFT;
                cnt_d   = cnt_nxt;
            end
        end
        if (sen && sof && state_q == ST_SHIFT) begin
            ferr_d = 1'b1;
        end
        if (done) begin
            if (!dvalid_q || dready) begin
                dout_d   = word;
                dvalid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (dvalid_q && dready) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = (state_q == ST_SHIFT);
    assign ovf    = ovf_q;
    assign ferr   = ferr_q;

endmodule

// File: tb/tb_shift_rx.sv
// tb_shift_rx: directed scenarios plus random traffic on an MSB-first
// and an LSB-first receiver, checked against a frame-level model.
module tb_shift_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sin = 1'b0, sen = 1'b0, sof = 1'b0;
    logic clr = 1'b0, dready = 1'b0;

    logic [3:0] dout_m, dout_l;
    logic dvalid_m, busy_m, ovf_m, ferr_m;
    logic dvalid_l, busy_l, ovf_l, ferr_l;

    int n_tests = 0;
    int n_fail = 0;

    // reference model state
    int         fbits[$];
    bit         in_frame;
    logic [3:0] e_dout_m, e_dout_l;
    bit         e_valid, e_ovf, e_ferr;

    always #5 clk = ~clk;

    shift_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sen(sen), .sof(sof),
        .clr(clr), .dout(dout_m), .dvalid(dvalid_m), .dready(dready),
        .busy(busy_m), .ovf(ovf_m), .ferr(ferr_m)
    );

    shift_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sen(sen), .sof(sof),
        .clr(clr), .dout(dout_l), .dvalid(dvalid_l), .dready(dready),
        .busy(busy_l), .ovf(ovf_l), .ferr(ferr_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        fbits.delete();
        in_frame = 0;
        e_dout_m = '0;
        e_dout_l = '0;
        e_valid  = 0;
        e_ovf    = 0;
        e_ferr   = 0;
    endtask

    // One clock edge of behaviour, computed from the frame rules.
    task automatic model_edge();
        bit complete = 0;
        bit set_ovf = 0;
        bit set_ferr = 0;
        logic [3:0] wm = '0;
        logic [3:0] wl = '0;
        if (sen) begin
            if (sof) begin
                if (in_frame) set_ferr = 1;
                fbits.delete();
                fbits.push_back(int'(sin));
                in_frame = 1;
            end else if (in_frame) begin
                fbits.push_back(int'(sin));
            end
            if (in_frame && fbits.size() == 4) begin
                complete = 1;
                for (int i = 0; i < 4; i++) begin
                    wm = wm | (4'(fbits[i]) << (3 - i));
                    wl = wl | (4'(fbits[i]) << i);
                end
                fbits.delete();
                in_frame = 0;
            end
        end
        if (complete) begin
            if (!e_valid || dready) begin
                e_dout_m = wm;
                e_dout_l = wl;
                e_valid  = 1;
            end else begin
                set_ovf = 1;
            end
        end else if (e_valid && dready) begin
            e_valid = 0;
        end
        if (clr) begin
            e_ovf  = 0;
            e_ferr = 0;
        end
        if (set_ovf) e_ovf = 1;
        if (set_ferr) e_ferr = 1;
    endtask

    task automatic check_all();
        chk("dout_msb", 32'(dout_m), 32'(e_dout_m));
        chk("dout_lsb", 32'(dout_l), 32'(e_dout_l));
        chk("dvalid_msb", 32'(dvalid_m), 32'(e_valid));
        chk("dvalid_lsb", 32'(dvalid_l), 32'(e_valid));
        chk("busy_msb", 32'(busy_m), 32'(in_frame));
        chk("busy_lsb", 32'(busy_l), 32'(in_frame));
        chk("ovf_msb", 32'(ovf_m), 32'(e_ovf));
        chk("ovf_lsb", 32'(ovf_l), 32'(e_ovf));
        chk("ferr_msb", 32'(ferr_m), 32'(e_ferr));
        chk("ferr_lsb", 32'(ferr_l), 32'(e_ferr));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(input logic s_en, input logic s_of,
                        input logic s_in, input logic rdy,
                        input logic cl);
        sen    = s_en;
        sof    = s_of;
        sin    = s_in;
        dready = rdy;
        clr    = cl;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic send(input logic [3:0] w, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, w[3-i], rdy, 1'b0);
        end
    endtask

    task automatic async_reset();
        sen = 0; sof = 0; clr = 0;
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("rst_dout_msb", 32'(dout_m), 32'h0);
        chk("rst_dout_lsb", 32'(dout_l), 32'h0);
        chk("rst_flags", {28'h0, dvalid_m, busy_m, ovf_m, ferr_m}, 32'h0);
        #2 rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1;
        @(negedge clk);
        idle(2, 1'b1);

        // MSB/LSB frame with dready high
        send(4'b0101, 1'b1);
        chk("msb_word", 32'(dout_m), 32'h5);
        chk("lsb_word", 32'(dout_l), 32'hA);
        chk("one_valid", 32'(dvalid_m), 32'h1);
        idle(1, 1'b1);
        chk("valid_drop", 32'(dvalid_m), 32'h0);

        // gaps mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("gap_lsb_word", 32'(dout_l), 32'hA);

        // backpressure and overflow
        idle(2, 1'b1);
        send(4'b0011, 1'b0);
        send(4'b1100, 1'b0);
        chk("bp_hold", 32'(dout_m), 32'h3);
        chk("bp_ovf", 32'(ovf_m), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_drain", 32'(dvalid_m), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clr", 32'(ovf_m), 32'h0);

        // abort then restart
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send(4'b1001, 1'b1);
        chk("abort_ferr", 32'(ferr_m), 32'h1);
        chk("abort_word", 32'(dout_m), 32'h9);

        // clr coinciding with a new abort keeps ferr set
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_vs_set", 32'(ferr_m), 32'h1);
        idle(1, 1'b1);

        // reset mid-frame with a held word
        send(4'b1111, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        async_reset();
        send(4'b0110, 1'b1);
        chk("post_rst_word", 32'(dout_m), 32'h6);

        // back-to-back frames
        idle(1, 1'b1);
        send(4'b0001, 1'b1);
        send(4'b0010, 1'b1);
        send(4'b0100, 1'b1);
        chk("b2b_word", 32'(dout_m), 32'h4);
        chk("b2b_ovf", 32'(ovf_m), 32'h0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic r_en, r_of, r_in, r_rdy, r_cl;
            r_en  = ($urandom_range(0, 9) < 7);
            r_of  = in_frame ? ($urandom_range(0, 15) == 0)
                             : ($urandom_range(0, 2) == 0);
            r_in  = 1'($urandom_range(0, 1));
            r_rdy = ($urandom_range(0, 9) < 6);
            r_cl  = ($urandom_range(0, 19) == 0);
            step(r_en, r_of, r_in, r_rdy, r_cl);
            if (c == 1500) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
